// File: rtl/mult_sequencer.sv
// mult_sequencer: sequential signed multiplier built from one shared adder.
// Operands become sign and magnitude. The magnitudes then go through a fixed
// 16-step shift-and-add. The sign is applied at the end, and any result
// outside the signed WIDTH-bit range is flagged as an overflow.
module mult_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  // Largest magnitudes that still fit once the sign is applied.
  localparam logic [AW-1:0] NEG_LIM = AW'(1) << (WIDTH - 1);
  localparam logic [AW-1:0] POS_LIM = NEG_LIM - AW'(1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SIGN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Operand magnitudes. The most negative value maps to 0x8000, which is
  // still correct when that pattern is read as unsigned.
  always_comb begin
    mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    mag_b = op_b[WIDTH-1] ? -op_b : op_b;
  end

  // Next-state logic. clear overrides everything, and it leaves the result
  // registers untouched.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_ITER;
          end
        end
        S_ITER: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = S_SIGN;
          end
        end
        S_SIGN: begin
          // The low bits of -acc equal the negation of acc's low bits.
          product_d  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          overflow_d = neg_q ? (acc_q > NEG_LIM) : (acc_q > POS_LIM);
          state_d    = S_SIGN == state_q ? S_DONE : state_q;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // done comes from its own flop, so no input reaches it combinationally.
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle signed 16-bit multiply sequencer for the calculator datapath. It replaces a single-cycle multiplier so the `*` operation uses one shared adder and a shift register. The general controller issues a `start` with two two's-complement operands, waits for `done`, then displays `product`. The block computes sign and magnitude separately, runs a fixed 16-step shift-and-add, restores the sign and flags results outside the 16-bit signed range.

## Interface
- `WIDTH`, 16, operand and product width; the width rules below are written for 16.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `clear`  in  1  synchronous abort; returns the block to IDLE.
- `op_a`  in  16  multiplicand, two's complement; sampled with `start`.
- `op_b`  in  16  multiplier, two's complement; sampled with `start`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; `product` and `overflow` are valid from this cycle onward.
- `product`  out  16  low 16 bits of the exact signed product.
- `overflow`  out  1  exact product is outside [-32768, 32767].

## Operation
- States: IDLE, ITER, SIGN, DONE.
- IDLE, `start`=1, `clear`=0:
  - `mcand` = |op_a| (32-bit), `mplier` = |op_b| (16-bit unsigned; |-32768| = 0x8000 fits).
  - `neg` = op_a[15] ^ op_b[15]; `acc` = 0; `cnt` = 0.
  - Next state ITER.
- ITER, once per cycle:
  - If `mplier[0]`, `acc` += `mcand`.
  - `mcand` <<= 1; `mplier` >>= 1; `cnt`++.
  - After the 16th step (`cnt` == 15 at the edge), go to SIGN.
  - There is no early exit; latency does not depend on the data.
- SIGN:
  - `res` = `neg` ? -`acc` : `acc`, 32-bit two's complement.
  - `product` <= `res`[15:0].
  - `overflow` <= `neg` ? (`acc` > 32768) : (`acc` > 32767).
  - Next state DONE.
- DONE: `done`=1 for this cycle only; next state IDLE.
- `product` and `overflow` change only on the SIGN→DONE edge. They hold their values until the next completed operation.
- `start` in ITER, SIGN or DONE is ignored. It is not queued, and the operands on the bus are not sampled.
- `start` held high continuously: a new operation is sampled on the first IDLE edge after DONE.
- `clear`:
  - Has priority over `start` and over all state transitions.
  - In any state it forces IDLE at the next edge.
  - No `done` is generated; `product` and `overflow` keep their previous values.
  - In IDLE it also suppresses a simultaneous `start`.
- Zero operands (0*x, x*0) follow the normal path: result 0, `overflow`=0.

## Timing
- Reset (`nRST`=0, at any time, including mid-operation):
  - State IDLE.
  - `busy`=0, `done`=0, `product`=0, `overflow`=0.
  - Internal `acc`, `mcand`, `mplier`, `cnt` and `neg` cleared.
- Let E0 be the rising edge that samples `start` in IDLE:
  - E1–E16: iteration edges.
  - E17: SIGN→DONE; `product`/`overflow` update.
  - `done`=1 between E17 and E18.
  - E18: returns to IDLE.
- `busy` is high from E0 until E18.
- Latency from sampling `start` to `done`: 17 cycles.
- Minimum issue interval: 19 cycles (next `start` sampled at E19).
- Operands need only be stable at E0. Changes on `op_a`/`op_b` afterwards have no effect.
- `done` is registered, with no combinational path from any input.

## Test plan
- -1 × -1 → `done` after 17 cycles; `product`=0x0001, `overflow`=0; `busy` high for exactly 18 cycles.
- 128 × 256 → `product`=0x8000, `overflow`=1. -32768 × 1 → 0x8000, `overflow`=0. -32768 × -1 → 0x8000, `overflow`=1.
- -12 × 3000 → `product`=0x7360 (low bits of -36000), `overflow`=1. 1234 × -5 → 0xE7E6 (-6170), `overflow`=0.
- 0 × 100 and 100 × 0 → `product`=0, `overflow`=0. `start` held high for two operations (4×3 then 5×5): `done` pulses 19 cycles apart with results 12 and 25.
- Start 7×9. Pulse `start` with op_a=2, op_b=2 at E5 → ignored; result 63. Then start 3×3 and assert `clear` at E8 → `busy` drops at E9, no `done`, `product` stays 63.
- Assert `nRST` low at E10 of an operation → all outputs are 0 immediately and stay 0. After release, 2×3 completes normally with `product`=6.
